// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared pointer types, buffer states and Gray conversion helpers for the async FIFO
package afifo_pkg;

    localparam int AFIFO_ADDR_WIDTH = 6;
    localparam int AFIFO_PTR_WIDTH  = AFIFO_ADDR_WIDTH + 1;

    typedef logic [AFIFO_PTR_WIDTH-1:0] ptr_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Values are carried in 32-bit containers; bits at and above width are cleared first.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
        logic [31:0] v;
        v = b & ((32'd1 << width) - 32'd1);
        return (v >> 1) ^ v;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] v;
        logic [31:0] b;
        v = g & ((32'd1 << width) - 32'd1);
        b = v;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ v[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_out_buf.sv
// rtl/rd_out_buf.sv - 2-entry head/skid output buffer for first-word-fall-through reads (AFIFO_FWFT_EN)
`ifdef AFIFO_FWFT_EN
module rd_out_buf
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_ldata,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    buf_state_t            r_state;
    buf_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  w_pop;

    assign w_pop = (r_state != BUF_EMPTY) & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BUF_EMPTY: if (i_load) w_next = BUF_ONE;
            BUF_ONE: begin
                if (w_pop & ~i_load) w_next = BUF_EMPTY;
                else if (~w_pop & i_load) w_next = BUF_TWO;
            end
            BUF_TWO:   if (w_pop & ~i_load) w_next = BUF_ONE;
            default:   w_next = BUF_EMPTY;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_occ   = 2'd0;
        case (r_state)
            BUF_ONE: begin o_valid = 1'b1; o_occ = 2'd1; end
            BUF_TWO: begin o_valid = 1'b1; o_occ = 2'd2; end
            default: begin o_valid = 1'b0; o_occ = 2'd0; end
        endcase
    end

    assign o_data = r_head;

    // Head always holds the oldest word; the skid only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: if (i_load) r_head <= i_ldata;
                BUF_ONE: begin
                    if (w_pop & i_load) r_head <= i_ldata;
                    else if (i_load)    r_skid <= i_ldata;
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                        if (i_load) r_skid <= i_ldata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`endif

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - async FIFO read-domain pointer/flag controller; AFIFO_FWFT_EN selects first-word-fall-through
module fifo_read_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int               PTR_W    = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0]      r_rbin;
    logic [PTR_W-1:0]      r_rptr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [PTR_W-1:0]      r_count;
    logic                  r_inflight;

    logic                  w_ren;
    logic [PTR_W-1:0]      w_rbin_next;
    logic [PTR_W-1:0]      w_rgray_next;
    logic [PTR_W-1:0]      w_wbin;
    logic [PTR_W-1:0]      w_count_next;

    assign w_rbin_next  = r_rbin + PTR_W'(w_ren);
    assign w_rgray_next = PTR_W'(bin2gray(32'(w_rbin_next), PTR_W));
    assign w_wbin       = PTR_W'(gray2bin(32'(rq2_wptr), PTR_W));
    // Modulo-2^PTR_W difference stays correct across pointer wrap.
    assign w_count_next = w_wbin - w_rbin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbin         <= '0;
            r_rptr         <= '0;
            r_raddr        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_count        <= '0;
            r_inflight     <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rptr         <= w_rgray_next;
            r_raddr        <= w_rbin_next[ADDR_WIDTH-1:0];
            r_empty        <= (w_rgray_next == rq2_wptr);
            r_almost_empty <= (w_count_next <= AE_LIMIT);
            r_count        <= w_count_next;
            r_inflight     <= w_ren;
        end
    end

`ifdef AFIFO_FWFT_EN
    logic                  w_buf_valid;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic [1:0]            w_occ;
    logic                  w_pop;
    logic [2:0]            w_level;

    rd_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (r_inflight),
        .i_ldata (rdata_mem),
        .i_ready (rd_ready),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_occ   (w_occ)
    );

    // Fetch only while buffered plus in-flight words, net of this cycle's transfer, leave room.
    assign w_pop    = w_buf_valid & rd_ready;
    assign w_level  = {1'b0, w_occ} + {2'b0, r_inflight};
    assign w_ren    = ~r_empty & (w_level < (3'd2 + {2'b0, w_pop}));
    assign rd_valid = w_buf_valid;
    assign rd_data  = w_buf_data;
`else
    assign w_ren    = rd_ready & ~r_empty;
    assign rd_valid = r_inflight;
    assign rd_data  = r_inflight ? rdata_mem : '0;
`endif

    assign ren          = w_ren;
    assign rptr         = r_rptr;
    assign raddr        = r_raddr;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_count;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl (standard mode, FWFT section under AFIFO_FWFT_EN)
module tb_fifo_read_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] rq2_wptr;
    logic [6:0] rptr;
    logic [5:0] raddr;
    logic       ren;
    logic [7:0] rdata_mem;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       empty;
    logic       almost_empty;
    logic [6:0] rd_count;

    int n_checks = 0;
    int n_errors = 0;

    fifo_read_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .AE_THRESH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rq2_wptr     (rq2_wptr),
        .rptr         (rptr),
        .raddr        (raddr),
        .ren          (ren),
        .rdata_mem    (rdata_mem),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & 127;
    endfunction

    function automatic int mem_word(input int a);
        return ((a & 63) * 37 + 11) & 255;
    endfunction

    // Memory model: one-cycle read latency
    always @(posedge clk) begin
        if (ren) rdata_mem <= 8'(mem_word(int'(raddr)));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rptr"},  int'(rptr), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_ae"},    int'(almost_empty), 1);
        chk({tag, "_count"}, int'(rd_count), 0);
        chk({tag, "_valid"}, int'(rd_valid), 0);
        chk({tag, "_data"},  int'(rd_data), 0);
        chk({tag, "_ren"},   int'(ren), 0);
    endtask

    // Reads with rd_ready held high from read pointer start_bin until it reaches target_bin.
    task automatic drain(input int start_bin, input int target_bin);
        int b;
        int cnt;
        b = start_bin;
        rd_ready = 1'b1;
        for (int c = 0; c < 80 && b != target_bin; c++) begin
            @(negedge clk);
            chk("drain_ren", int'(ren), 1);
            @(posedge clk); #1;
            b = (b + 1) & 127;
            cnt = (target_bin - b) & 127;
            chk("drain_rptr",  int'(rptr), g(b));
            chk("drain_raddr", int'(raddr), b & 63);
            chk("drain_count", int'(rd_count), cnt);
            chk("drain_empty", int'(empty), (b == target_bin) ? 1 : 0);
            chk("drain_ae",    int'(almost_empty), (cnt <= 4) ? 1 : 0);
            chk("drain_valid", int'(rd_valid), 1);
            chk("drain_data",  int'(rd_data), mem_word((b - 1) & 63));
        end
        chk("drain_reached_target", b, target_bin);
        @(negedge clk);
        chk("drain_ren_when_empty", int'(ren), 0);
        @(posedge clk); #1;
        chk("drain_rptr_hold", int'(rptr), g(target_bin));
        chk("drain_valid_end", int'(rd_valid), 0);
        rd_ready = 1'b0;
    endtask

    typedef struct {
        int wbin;
        int rdy;
        int exp_ren;
        int exp_empty;
        int exp_ae;
        int exp_cnt;
        int exp_rbin;
        int exp_valid;
        int exp_daddr;
    } vec_t;

    vec_t vecs[8];

`ifdef AFIFO_FWFT_EN
    int   n_xfer;
    int   n_extra;
    logic stalled;
    logic [7:0] held;
`endif

    initial begin
        vecs[0] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[2] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        vecs[3] = '{1, 1, 0, 1, 1, 0, 1, 0, 0};
        vecs[4] = '{6, 0, 0, 0, 0, 5, 1, 0, 0};
        vecs[5] = '{6, 1, 1, 0, 1, 4, 2, 1, 1};
        vecs[6] = '{8, 1, 1, 0, 0, 5, 3, 1, 2};
        vecs[7] = '{8, 0, 0, 0, 0, 5, 3, 0, 0};

        rst_n    = 1'b0;
        rd_ready = 1'b0;
        rq2_wptr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n    = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("empty_read_ren", int'(ren), 0);
            @(posedge clk); #1;
            chk("empty_read_rptr", int'(rptr), 0);
        end
        rd_ready = 1'b0;

`ifndef AFIFO_FWFT_EN
        foreach (vecs[i]) begin
            rq2_wptr = 7'(g(vecs[i].wbin));
            rd_ready = 1'(vecs[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_ren", i), int'(ren), vecs[i].exp_ren);
            @(posedge clk); #1;
            chk($sformatf("v%0d_empty", i), int'(empty), vecs[i].exp_empty);
            chk($sformatf("v%0d_ae", i),    int'(almost_empty), vecs[i].exp_ae);
            chk($sformatf("v%0d_count", i), int'(rd_count), vecs[i].exp_cnt);
            chk($sformatf("v%0d_rptr", i),  int'(rptr), g(vecs[i].exp_rbin));
            chk($sformatf("v%0d_raddr", i), int'(raddr), vecs[i].exp_rbin & 63);
            chk($sformatf("v%0d_valid", i), int'(rd_valid), vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0)
                chk($sformatf("v%0d_data", i), int'(rd_data), mem_word(vecs[i].exp_daddr));
        end

        // Reset with a read in flight
        rd_ready = 1'b1;
        @(posedge clk); #1;
        chk("midreset_inflight_valid", int'(rd_valid), 1);
        #1;
        rst_n    = 1'b0;
        rq2_wptr = '0;
        #1;
        chk_reset_outputs("midreset");
        rd_ready = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_valid", int'(rd_valid), 0);
        end

        // Full FIFO drained at one word per cycle
        rq2_wptr = 7'(g(64));
        @(posedge clk); #1;
        chk("full_empty", int'(empty), 0);
        chk("full_count", int'(rd_count), 64);
        chk("full_ae",    int'(almost_empty), 0);
        drain(0, 64);

        // Position the read pointer at 126, then drain across the wrap
        rq2_wptr = 7'(g(126));
        @(posedge clk); #1;
        chk("pre_wrap_count", int'(rd_count), 62);
        drain(64, 126);
        rq2_wptr = 7'(g(2));
        @(posedge clk); #1;
        chk("wrap_count", int'(rd_count), 4);
        chk("wrap_empty", int'(empty), 0);
        chk("wrap_ae",    int'(almost_empty), 1);
        drain(126, 2);
`else
        // First word falls through two cycles after empty drops
        rq2_wptr = 7'(g(10));
        @(posedge clk); #1;
        chk("fwft_empty_fall", int'(empty), 0);
        chk("fwft_valid_c0", int'(rd_valid), 0);
        @(posedge clk); #1;
        chk("fwft_valid_c1", int'(rd_valid), 0);
        @(posedge clk); #1;
        chk("fwft_valid_c2", int'(rd_valid), 1);
        chk("fwft_first_data", int'(rd_data), mem_word(0));

        n_xfer  = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 400 && n_xfer < 10; c++) begin
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) begin
                chk("fwft_stall_valid", int'(rd_valid), 1);
                chk("fwft_stall_data", int'(rd_data), int'(held));
            end
            if (rd_valid && rd_ready) begin
                chk($sformatf("fwft_xfer%0d_data", n_xfer), int'(rd_data), mem_word(n_xfer));
                n_xfer++;
            end
            stalled = rd_valid & ~rd_ready;
            held    = rd_data;
            @(posedge clk); #1;
        end
        chk("fwft_xfer_count", n_xfer, 10);
        rd_ready = 1'b1;
        n_extra  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_valid) n_extra++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        chk("fwft_no_extra_words", n_extra, 0);
        chk("fwft_end_empty", int'(empty), 1);
        chk("fwft_end_rptr", int'(rptr), g(10));
        chk("fwft_end_count", int'(rd_count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
